mem_stream_reader: RTL

- Read-side initiator for the byte-addressed 32-bit data memory, which has a combinational little-endian word read.
- On a start pulse it walks a word-aligned address range and fetches one 32-bit word per accepted beat.
- It presents each word on a valid/ready stream, for example to feed sine-table samples from 0x10000 to a DAC/output path.
- Optional loop mode replays the table continuously.

---
 rtl/mem_stream_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// Streams a word-aligned range of the data memory onto a valid/ready interface.
// Optional loop mode replays the range with one bubble cycle per wrap.
module mem_stream_reader #(
  parameter int unsigned STRIDE    = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [31:0]          base_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  input  logic                 loop,
  output logic [31:0]          mem_A,
  output logic                 mem_WE,
  input  logic [31:0]          mem_RD,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t               state;
  logic [31:0]          addr;
  logic [31:0]          base;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] count;
  logic                 loop_r;

  logic take;
  logic slot;

  assign take   = out_valid && out_ready;
  assign slot   = !out_valid || take;
  assign mem_A  = addr;
  assign mem_WE = 1'b0;
  assign busy   = (state == STREAM);

  // Control FSM with registered stream outputs; stop overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      base      <= '0;
      remaining <= '0;
      count     <= '0;
      loop_r    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (word_count != '0) begin
                base      <= base_addr;
                count     <= word_count;
                loop_r    <= loop;
                addr      <= base_addr;
                remaining <= word_count;
                state     <= STREAM;
              end else begin
                done <= 1'b1;
              end
            end
          end
          STREAM: begin
            if (slot) begin
              if (remaining != '0) begin
                out_data  <= mem_RD;
                out_valid <= 1'b1;
                addr      <= addr + 32'(STRIDE);
                remaining <= remaining - CNT_WIDTH'(1);
              end else if (loop_r) begin
                // Rewind; the slot spent here is the single bubble per pass.
                addr      <= base;
                remaining <= count;
                if (take) out_valid <= 1'b0;
              end else begin
                out_valid <= 1'b0;
                state     <= IDLE;
                done      <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
